// File: rtl/text_console_if.sv
// Character stream, buffer port and cursor status between the console and its neighbours.
// The slave side is the console itself; the master side is the byte source plus the character RAM.
// Guarded build option of the console (CONSOLE_TAB_EN) does not change this interface.
interface text_console_if #(
    parameter int ADDR_W = 12,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [7:0]        ram_rdata;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row;
    logic              busy;

    modport master (
        output in_valid, in_data, ram_rdata,
        input  in_ready, ram_wren, ram_waddr, ram_wdata, ram_raddr, cur_col, cur_row, busy
    );

    modport slave (
        input  in_valid, in_data, ram_rdata,
        output in_ready, ram_wren, ram_waddr, ram_wdata, ram_raddr, cur_col, cur_row, busy
    );
endinterface

// File: rtl/text_console.sv
// Purpose: cursor-tracking front end writing ASCII bytes into the COLSxROWS character buffer (TAB expansion with CONSOLE_TAB_EN).
// Latency: one WRITE cycle per byte; scroll (ROWS-1)*COLS+1 + COLS cycles; form-feed COLS*ROWS cycles.
// Backpressure: in_ready only in IDLE, so exactly one byte is in flight; busy covers every non-IDLE cycle.
module text_console #(
    parameter int COLS   = 70,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5
) (
    input logic          sys_clk,
    input logic          rst,
    text_console_if.slave bus
);
`ifdef CONSOLE_TAB_EN
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_SCROLL, S_CLEAR_LINE, S_CLEAR_ALL, S_TAB} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_SCROLL, S_CLEAR_LINE, S_CLEAR_ALL} state_t;
`endif

    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] COPY_N   = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(COLS * ROWS - 1);

    state_t            r_state;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_idx;    // row*COLS+col, kept incrementally
    logic [7:0]        r_byte;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_wren;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wdata;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_copy;   // write data comes straight from the read port during scroll

    logic [COL_W-1:0]  w_adv_col;
    logic [ROW_W-1:0]  w_adv_row;
    logic [ADDR_W-1:0] w_adv_idx;
    logic              w_adv_scroll;
    logic [ADDR_W-1:0] w_col_ext;
    logic [ROW_W-1:0]  w_nl_row;
    logic [ADDR_W-1:0] w_nl_idx;

    function automatic logic f_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    // Next cursor position for a one-column advance and for a newline; the last row scrolls instead of moving.
    always_comb begin
        w_col_ext    = ADDR_W'(r_col);
        w_adv_col    = r_col + 1'b1;
        w_adv_row    = r_row;
        w_adv_idx    = r_idx + 1'b1;
        w_adv_scroll = 1'b0;
        w_nl_row     = r_row;
        w_nl_idx     = COPY_N;
        if (r_col == LAST_COL) begin
            w_adv_col = '0;
            if (r_row == LAST_ROW) begin
                w_adv_scroll = 1'b1;
                w_adv_idx    = COPY_N;
            end else begin
                w_adv_row = r_row + 1'b1;
            end
        end
        if (r_row != LAST_ROW) begin
            w_nl_row = r_row + 1'b1;
            w_nl_idx = r_idx - w_col_ext + COLS_A;
        end
    end

    // Control FSM: byte decode, cursor update, pipelined scroll copy and clears; all outputs registered.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_idx   <= '0;
            r_byte  <= '0;
            r_cnt   <= '0;
            r_wren  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_raddr <= '0;
            r_copy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wren <= 1'b0;
                    r_copy <= 1'b0;
                    if (bus.in_valid) begin
                        r_byte  <= bus.in_data;
                        r_wdata <= 8'h20;
                        r_waddr <= r_idx;
                        if (bus.in_data == 8'h0C) begin
                            r_state <= S_CLEAR_ALL;
                            r_wren  <= 1'b1;
                            r_waddr <= '0;
                        end
`ifdef CONSOLE_TAB_EN
                        else if (bus.in_data == 8'h09) begin
                            r_state <= S_TAB;
                            r_wren  <= 1'b1;
                        end
`endif
                        else begin
                            r_state <= S_WRITE;
                            if (f_printable(bus.in_data)) begin
                                r_wren  <= 1'b1;
                                r_wdata <= bus.in_data;
                            end else if (bus.in_data == 8'h08 && (r_col != '0 || r_row != '0)) begin
                                // one cell back is idx-1 whether or not the row changes
                                r_wren  <= 1'b1;
                                r_waddr <= r_idx - 1'b1;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    r_wren  <= 1'b0;
                    r_state <= S_IDLE;
                    if (f_printable(r_byte)) begin
                        r_col <= w_adv_col;
                        r_row <= w_adv_row;
                        r_idx <= w_adv_idx;
                        if (w_adv_scroll) begin
                            r_state <= S_SCROLL;
                            r_cnt   <= '0;
                            r_raddr <= COLS_A;
                        end
                    end else if (r_byte == 8'h0A) begin
                        r_col <= '0;
                        r_row <= w_nl_row;
                        r_idx <= w_nl_idx;
                        if (r_row == LAST_ROW) begin
                            r_state <= S_SCROLL;
                            r_cnt   <= '0;
                            r_raddr <= COLS_A;
                        end
                    end else if (r_byte == 8'h0D) begin
                        r_col <= '0;
                        r_idx <= r_idx - w_col_ext;
                    end else if (r_byte == 8'h08) begin
                        if (r_col != '0) begin
                            r_col <= r_col - 1'b1;
                            r_idx <= r_idx - 1'b1;
                        end else if (r_row != '0) begin
                            r_row <= r_row - 1'b1;
                            r_col <= LAST_COL;
                            r_idx <= r_idx - 1'b1;
                        end
                    end
                end
                S_SCROLL: begin
                    // cycle k reads k+COLS; cycle k+1 writes that data to k
                    if (r_cnt == COPY_N) begin
                        r_state <= S_CLEAR_LINE;
                        r_copy  <= 1'b0;
                        r_wren  <= 1'b1;
                        r_wdata <= 8'h20;
                        r_waddr <= COPY_N;
                    end else begin
                        r_copy  <= 1'b1;
                        r_wren  <= 1'b1;
                        r_waddr <= r_cnt;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt + 1'b1 != COPY_N) begin
                            r_raddr <= r_raddr + 1'b1;
                        end
                    end
                end
                S_CLEAR_LINE: begin
                    if (r_waddr == LAST_IDX) begin
                        r_wren  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_waddr <= r_waddr + 1'b1;
                    end
                end
                S_CLEAR_ALL: begin
                    if (r_waddr == LAST_IDX) begin
                        r_wren  <= 1'b0;
                        r_state <= S_IDLE;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_waddr <= r_waddr + 1'b1;
                    end
                end
`ifdef CONSOLE_TAB_EN
                S_TAB: begin
                    // a space was written at the cursor this cycle; advance and decide whether to go on
                    r_col <= w_adv_col;
                    r_row <= w_adv_row;
                    r_idx <= w_adv_idx;
                    if (r_col == LAST_COL) begin
                        r_wren <= 1'b0;
                        if (w_adv_scroll) begin
                            r_state <= S_SCROLL;
                            r_cnt   <= '0;
                            r_raddr <= COLS_A;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_adv_col[2:0] == 3'b000) begin
                        r_wren  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_waddr <= w_adv_idx;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_wren  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE) && !rst;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.ram_wren  = r_wren;
    assign bus.ram_waddr = r_waddr;
    assign bus.ram_wdata = r_copy ? bus.ram_rdata : r_wdata;
    assign bus.ram_raddr = r_raddr;
    assign bus.cur_col   = r_col;
    assign bus.cur_row   = r_row;
endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: screen-level reference model, character RAM model and write-stream monitor.
// Directed cases for wrap, backspace, scroll, clear and reset mid-clear, then random byte streams.
// TAB expectations follow CONSOLE_TAB_EN when the bench is built with the same define.
module tb_text_console;
    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    always #5 sys_clk = ~sys_clk;

    text_console_if #(.ADDR_W(12), .COL_W(7), .ROW_W(5)) bus ();

    text_console #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(12), .COL_W(7), .ROW_W(5)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // character RAM: synchronous write, read data one cycle after the address
    logic [7:0] mem      [CELLS];
    logic [7:0] load_buf [CELLS];
    logic       load_req;
    always @(posedge sys_clk) begin
        if (load_req) begin
            for (int a = 0; a < CELLS; a++) mem[a] <= load_buf[a];
        end else if (bus.ram_wren && int'(bus.ram_waddr) < CELLS) begin
            mem[int'(bus.ram_waddr)] <= bus.ram_wdata;
        end
        bus.ram_rdata <= (int'(bus.ram_raddr) < CELLS) ? mem[int'(bus.ram_raddr)] : 8'h00;
    end

    // write-stream monitor
    int wq_a[$];
    int wq_d[$];
    int idle_wr = 0;
    always @(negedge sys_clk) begin
        if (bus.ram_wren === 1'b1) begin
            wq_a.push_back(int'(bus.ram_waddr));
            wq_d.push_back(int'(bus.ram_wdata));
            if (bus.busy !== 1'b1) idle_wr++;
        end
    end

    function automatic int wa(input int i);
        return (i < wq_a.size()) ? wq_a[i] : -1;
    endfunction
    function automatic int wd(input int i);
        return (i < wq_d.size()) ? wq_d[i] : -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d, expected %0d", tag, act, exp);
        end
    endtask

    // reference model: screen array, cursor, expected write list and busy-cycle count
    logic [7:0] scr [CELLS];
    int mc, mr, e_busy;
    int ea[$];
    int ed[$];

    task automatic m_write(input int a, input int d);
        scr[a] = 8'(d);
        ea.push_back(a);
        ed.push_back(d);
    endtask

    task automatic m_newline();
        if (mr == ROWS - 1) begin
            for (int k = 0; k < CELLS - COLS; k++) m_write(k, int'(scr[k + COLS]));
            for (int k = CELLS - COLS; k < CELLS; k++) m_write(k, 32);
            e_busy += (ROWS - 1) * COLS + 1 + COLS;
        end else begin
            mr++;
        end
    endtask

    task automatic m_advance(output bit wrapped);
        wrapped = 0;
        mc++;
        if (mc == COLS) begin
            mc = 0;
            wrapped = 1;
            m_newline();
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit w;
        ea.delete();
        ed.delete();
        e_busy = 1;
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_write(mr * COLS + mc, int'(b));
            m_advance(w);
        end else if (b == 8'h0A) begin
            mc = 0;
            m_newline();
        end else if (b == 8'h0D) begin
            mc = 0;
        end else if (b == 8'h08) begin
            if (mc > 0 || mr > 0) begin
                if (mc > 0) mc--;
                else begin mr--; mc = COLS - 1; end
                m_write(mr * COLS + mc, 32);
            end
        end else if (b == 8'h0C) begin
            e_busy = CELLS;
            for (int a = 0; a < CELLS; a++) m_write(a, 32);
            mc = 0;
            mr = 0;
        end
`ifdef CONSOLE_TAB_EN
        else if (b == 8'h09) begin
            e_busy = 0;
            for (int g = 0; g < COLS; g++) begin
                m_write(mr * COLS + mc, 32);
                e_busy++;
                m_advance(w);
                if (w || (mc % 8) == 0) break;
            end
        end
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n, mis, diff;
        model_byte(b);
        wq_a.delete();
        wq_d.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 8) begin @(negedge sys_clk); n++; end
        @(negedge sys_clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 6000) begin n++; @(negedge sys_clk); end
        chk($sformatf("busy_cycles[%02h]", b), n, e_busy);
        chk($sformatf("wr_count[%02h]", b), wq_a.size(), ea.size());
        mis = 0;
        for (int i = 0; i < wq_a.size() && i < ea.size(); i++)
            if (wq_a[i] != ea[i] || wq_d[i] != ed[i]) mis++;
        chk($sformatf("wr_seq[%02h]", b), mis, 0);
        chk($sformatf("cur_col[%02h]", b), bus.cur_col, mc);
        chk($sformatf("cur_row[%02h]", b), bus.cur_row, mr);
        diff = 0;
        for (int a = 0; a < CELLS; a++) if (mem[a] !== scr[a]) diff++;
        chk($sformatf("screen[%02h]", b), diff, 0);
    endtask

    task automatic preload(input bit by_row);
        logic [7:0] v;
        for (int a = 0; a < CELLS; a++) begin
            v = by_row ? 8'(a / COLS + 8'h30) : 8'($urandom);
            load_buf[a] = v;
            scr[a]      = v;
        end
        @(negedge sys_clk);
        load_req = 1'b1;
        @(negedge sys_clk);
        load_req = 1'b0;
    endtask

    function automatic logic [7:0] rnd_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 76) return 8'($urandom_range(32, 126));
        if (r < 80) return 8'h0A;
        if (r < 84) return 8'h0D;
        if (r < 90) return 8'h08;
        if (r < 95) begin
            case ($urandom_range(0, 3))
                0: return 8'($urandom_range(127, 255));
                1: return 8'h00;
                2: return 8'h1B;
                default: return 8'h07;
            endcase
        end
        if (r < 99) return 8'h09;
        return 8'h0C;
    endfunction

    logic [7:0] last_p;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        load_req     = 1'b0;
        mc = 0;
        mr = 0;
        preload(1'b0);
        @(negedge sys_clk);
        chk("in_ready_in_rst", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wren", bus.ram_wren, 0);
        chk("rst_waddr", bus.ram_waddr, 0);
        chk("rst_wdata", bus.ram_wdata, 0);
        chk("rst_raddr", bus.ram_raddr, 0);
        chk("rst_col", bus.cur_col, 0);
        chk("rst_row", bus.cur_row, 0);

        // two printables
        send_byte(8'h41);
        chk("A_addr", wa(0), 0);
        chk("A_data", wd(0), 8'h41);
        send_byte(8'h42);
        chk("B_addr", wa(0), 1);
        chk("B_data", wd(0), 8'h42);
        chk("AB_col", bus.cur_col, 2);

        // full-row wrap
        send_byte(8'h0D);
        for (int i = 0; i < COLS; i++) begin
            last_p = 8'($urandom_range(32, 126));
            send_byte(last_p);
        end
        chk("wrap_last_addr", wa(0), 69);
        chk("wrap_col", bus.cur_col, 0);
        chk("wrap_row", bus.cur_row, 1);
        send_byte(8'h5A);
        chk("Z_addr", wa(0), 70);

        // backspace within a row and across a row boundary
        send_byte(8'h0D);
        send_byte(8'h0A);
        send_byte(8'h0A);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(32, 126)));
        send_byte(8'h08);
        chk("bs_addr", wa(0), 214);
        chk("bs_data", wd(0), 8'h20);
        chk("bs_col", bus.cur_col, 4);
        send_byte(8'h0D);
        send_byte(8'h08);
        chk("bs_wrap_addr", wa(0), 209);
        chk("bs_wrap_col", bus.cur_col, 69);
        chk("bs_wrap_row", bus.cur_row, 2);

        // form feed, then backspace at the origin
        send_byte(8'h0C);
        chk("ff_writes", wq_a.size(), CELLS);
        chk("ff_last_addr", wa(CELLS - 1), CELLS - 1);
        send_byte(8'h08);
        chk("bs_origin_writes", wq_a.size(), 0);

        // tab
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(32, 126)));
        send_byte(8'h09);
`ifdef CONSOLE_TAB_EN
        chk("tab1_writes", wq_a.size(), 5);
        chk("tab1_first", wa(0), 3);
        chk("tab1_col", bus.cur_col, 8);
        send_byte(8'h09);
        chk("tab2_writes", wq_a.size(), 8);
        chk("tab2_col", bus.cur_col, 16);
`else
        chk("tab_off_writes", wq_a.size(), 0);
        chk("tab_off_col", bus.cur_col, 3);
`endif

        // scroll from the last row
        send_byte(8'h0D);
        for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A);
        chk("pre_scroll_row", bus.cur_row, ROWS - 1);
        preload(1'b1);
        send_byte(8'h0A);
        chk("scroll_busy", 32'(e_busy), 1 + 2031 + COLS);
        chk("scroll_mem0", mem[0], 8'h31);
        chk("scroll_mem2029", mem[2029], 8'h4D);
        chk("scroll_mem2030", mem[2030], 8'h20);
        chk("scroll_mem2099", mem[2099], 8'h20);
        chk("scroll_row", bus.cur_row, ROWS - 1);

        // random streams from a clean screen
        send_byte(8'h0C);
        for (int i = 0; i < 300; i++) send_byte(rnd_byte());

        // reset in the middle of a clear
        wq_a.delete();
        wq_d.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h0C;
        @(negedge sys_clk);
        bus.in_valid = 1'b0;
        repeat (499) @(negedge sys_clk);
        chk("clear_busy_mid", bus.busy, 1);
        rst = 1'b1;
        @(negedge sys_clk);
        chk("abort_wren", bus.ram_wren, 0);
        chk("abort_col", bus.cur_col, 0);
        chk("abort_row", bus.cur_row, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_consecutive", wa(wq_a.size() - 1), wq_a.size() - 1);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", bus.in_ready, 1);
        mc = 0;
        mr = 0;
        send_byte(8'h0C);
        for (int i = 0; i < 40; i++) send_byte(rnd_byte());

        chk("wren_in_idle", idle_wr, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/text_console.md
Name: text_console

Overview:
- Character-stream front end of the text display; sits directly upstream of the VGA text scanout.
- Accepts ASCII bytes from CPU/keyboard path via valid/ready.
- Maintains a cursor and drives the write port of the 70x30 character buffer, which the scanout reads.
- Handles wrap, newline, carriage return, backspace, form-feed clear and hardware scroll, where scroll is a read-then-write copy through the buffer's read port.

Parameters:
- COLS, 70, characters per row
- ROWS, 30, rows per screen
- ADDR_W, 12, character-index width (COLS*ROWS <= 2^ADDR_W)
- COL_W, 7, cursor column width
- ROW_W, 5, cursor row width

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  in_data holds a character
- in_data  in  8  ASCII byte
- in_ready  out  1  block can accept a byte this cycle
- ram_wren  out  1  character buffer write enable
- ram_waddr  out  ADDR_W  write character index (row*COLS+col, not byte address)
- ram_wdata  out  8  write data
- ram_raddr  out  ADDR_W  read character index
- ram_rdata  in  8  read data, valid exactly 1 cycle after ram_raddr
- cur_col  out  COL_W  cursor column 0..COLS-1
- cur_row  out  ROW_W  cursor row 0..ROWS-1
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - state IDLE; cur_col=0, cur_row=0.
  - ram_wren=0; ram_waddr, ram_wdata, ram_raddr = 0.
  - busy=0, in_ready=1.
  - Buffer contents are not touched.
  - Reset mid-scroll/clear aborts at once; partially updated buffer is accepted.
- Handshake:
  - in_ready = (state==IDLE) && !rst.
  - A byte is accepted on a cycle with in_valid && in_ready; it is latched and state leaves IDLE on the next edge.
  - One byte in flight at a time.
- States: IDLE, WRITE, SCROLL, CLEAR_LINE, CLEAR_ALL, TAB (optional).
- Printable 0x20..0x7E:
  - WRITE: one cycle, ram_wren=1, waddr = cursor index, wdata = byte.
  - Then col+1, return to IDLE.
  - If col was COLS-1: col=0, row+1.
- 0x0A: col=0, row+1; no write; one cycle in WRITE with wren=0.
- 0x0D: col=0; no write.
- 0x08:
  - If col>0: col-1, then write 0x20 at the new position.
  - Else if row>0: row-1, col=COLS-1, write 0x20 there.
  - At (0,0): no-op.
- 0x0C:
  - CLEAR_ALL writes 0x20 to indices 0..COLS*ROWS-1, one per cycle (2100 cycles at defaults).
  - Then cursor=(0,0).
- Other bytes < 0x20 and 0x7F..0xFF: ignored, no write, cursor unchanged.
- Row overflow: any row+1 from row ROWS-1 enters SCROLL instead; row stays ROWS-1.
- SCROLL (pipelined, 1 char/cycle):
  - Cycle k issues ram_raddr = k+COLS for k = 0..(ROWS-1)*COLS-1.
  - Cycle k+1 writes ram_rdata to waddr = k.
  - Duration (ROWS-1)*COLS+1 cycles.
  - Then CLEAR_LINE writes 0x20 to indices (ROWS-1)*COLS..ROWS*COLS-1 (COLS cycles), then IDLE.
- Ordering: the printable write at the last cell always completes before the scroll starts.
- Arithmetic:
  - Cursor index = row*COLS+col, truncated to ADDR_W; may be kept incrementally.
  - Must equal the product form at every write.
- ram_wren is never asserted in IDLE.

Optional Feature:
- Macro CONSOLE_TAB_EN.
- Defined:
  - 0x09 enters TAB; writes 0x20 at cursor and advances one column per cycle.
  - Stops when col is a multiple of 8 after at least one write.
  - Crossing COLS-1 wraps as printable, including scroll, and the tab ends there.
- Undefined: 0x09 is ignored like other control bytes; TAB state absent.

Test Plan:
- After reset, send 'A'(0x41), 'B' -> writes (0,0x41), (1,0x42); cursor (2,0); in_ready low exactly 1 cycle per byte after acceptance.
- Send 70 printables, then 'Z' -> 70th at index 69; cursor wraps to (0,1); 'Z' written at index 70.
- Cursor (5,3), send 0x08 -> 0x20 written at index 214; cursor (4,3). At (0,3) -> 0x20 at index 209; cursor (69,2). At (0,0) -> no write.
- Preload row r with byte r+0x30, cursor (0,29), send 0x0A -> 2031 scroll cycles; index 0 gets 0x31, index 2029 gets 0x4D; indices 2030..2099 get 0x20; cursor (0,29); busy high throughout.
- Send 0x0C mid-screen -> 2100 consecutive writes of 0x20; cursor (0,0). Assert rst at cycle 500 of the clear -> next cycle wren=0, cursor (0,0), in_ready=1.
- CONSOLE_TAB_EN: cursor (3,0), send 0x09 -> spaces at 3..7, cursor (8,0). At (8,0) -> 8 spaces, cursor (16,0). Without the macro -> no write, cursor unchanged.
